// File: rtl/div_iter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_iter_pkg : shared FSM encodings, step count and helpers for div_iter
// Revision: 1.0
// ---------------------------------------------------------------------------
package div_iter_pkg;

  localparam logic [1:0] c_ST_IDLE        = 2'b00;
  localparam logic [1:0] c_ST_DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] c_ST_ON          = 2'b10;
  localparam logic [1:0] c_ST_END         = 2'b11;

  localparam int         c_DIV_CYCLES = 32;
  localparam int         c_CNT_W      = 5;
  localparam logic [4:0] c_LAST_STEP  = 5'(c_DIV_CYCLES - 1);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_iter_if : request/result handshake between a pipeline and div_iter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface div_iter_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_iter_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_iter_step : one radix-2 restoring step on the {remainder, quotient} word
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_iter_step
  import div_iter_pkg::*;
(
  input  logic [64:0] work,
  input  logic [31:0] divisor,
  output logic [64:0] work_nxt
);

  logic        w_ge;
  logic [32:0] w_diff;

  // Compare the shifted partial remainder work[64:31] against the divisor.
  assign w_ge     = work[64:31] >= {2'b00, divisor};
  assign w_diff   = work[63:31] - {1'b0, divisor};
  assign work_nxt = w_ge ? {w_diff, work[30:0], 1'b1} : {work[63:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_iter : 32-cycle iterative signed/unsigned divider, result {rem, quo}
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_iter
  import div_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [64:0]        r_work;
  logic [64:0]        w_step;
  logic [31:0]        r_divisor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_ready;
  logic [63:0]        r_result;
  logic               w_ready_nxt;
  logic [63:0]        w_result_nxt;
  logic               w_start_ok;
  logic [31:0]        w_quo_fix;
  logic [31:0]        w_rem_fix;

  assign w_start_ok = bus.start_i & ~bus.annul_i;

  div_iter_step u_step (
    .work     (r_work),
    .divisor  (r_divisor),
    .work_nxt (w_step)
  );

  assign w_quo_fix = r_neg_q ? neg32(w_step[31:0])  : w_step[31:0];
  assign w_rem_fix = r_neg_r ? neg32(w_step[63:32]) : w_step[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (bus.opdata2_i == 32'd0) ? c_ST_DIV_BY_ZERO : c_ST_ON;
        end
      end
      c_ST_DIV_BY_ZERO: w_state_nxt = c_ST_END;
      c_ST_ON: begin
        if (bus.annul_i) begin
          w_state_nxt = c_ST_IDLE;
        end else if (r_cnt == c_LAST_STEP) begin
          w_state_nxt = c_ST_END;
        end
      end
      c_ST_END: begin
        if (!bus.start_i || bus.annul_i) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; result is zero whenever not ready.
  always_comb begin
    w_ready_nxt  = 1'b0;
    w_result_nxt = 64'h0;
    case (r_state)
      c_ST_DIV_BY_ZERO: w_ready_nxt = 1'b1;
      c_ST_ON: begin
        if (!bus.annul_i && r_cnt == c_LAST_STEP) begin
          w_ready_nxt  = 1'b1;
          w_result_nxt = {w_rem_fix, w_quo_fix};
        end
      end
      c_ST_END: begin
        if (w_start_ok) begin
          w_ready_nxt  = 1'b1;
          w_result_nxt = r_result;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= 64'h0;
    end else begin
      r_ready  <= w_ready_nxt;
      r_result <= w_result_nxt;
      case (r_state)
        c_ST_IDLE: begin
          if (w_start_ok) begin
            r_cnt     <= '0;
            r_work    <= {33'd0, bus.signed_div_i ? abs32(bus.opdata1_i) : bus.opdata1_i};
            r_divisor <= bus.signed_div_i ? abs32(bus.opdata2_i) : bus.opdata2_i;
            r_neg_q   <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            r_neg_r   <= bus.signed_div_i & bus.opdata1_i[31];
          end
        end
        c_ST_ON: begin
          if (bus.annul_i) begin
            r_cnt  <= '0;
            r_work <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_work <= w_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;

endmodule
`default_nettype wire
